// File: rtl/scan_mux_if.sv
// Channel bus and output handshake for scan_mux.
// The master side is the mux; the slave side feeds channels and consumes the output.
interface scan_mux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  ch_data,
    input  ch_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport slave (
    output ch_data,
    output ch_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/scan_mux.sv
// Registered N-channel W-bit mux with fixed-select or auto-scan sequencing and a valid/ready output stage.
// Optional macro SCAN_SKIP_IDLE_EN: in scan mode, channels whose ch_valid is low are skipped immediately.
module scan_mux #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 16,
  localparam int SW    = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_mux_if.master    bus,
  input  logic          mode,
  input  logic [SW-1:0] sel_in,
  input  logic          sel_load,
  output logic [SW-1:0] cur_sel,
  output logic          wrap
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_cur_sel;
  logic [CW-1:0] r_cnt;
  logic          r_wrap;

  logic [W-1:0]  w_ch [N_CH];
  logic [W-1:0]  w_sel_data;
  logic          w_sel_valid;
  logic          w_load_en;
  logic          w_sel_legal;
  logic          w_last;
  logic          w_dwell_done;
  logic          w_skip;
  logic          w_advance;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_ch[gi] = bus.ch_data[gi*W +: W];
    end
  endgenerate

  assign w_sel_data   = w_ch[r_cur_sel];
  assign w_sel_valid  = bus.ch_valid[r_cur_sel];
  assign w_load_en    = !r_out_valid || bus.out_ready;
  assign w_sel_legal  = {1'b0, sel_in} < (SW+1)'(N_CH);
  assign w_last       = (r_cur_sel == SW'(N_CH - 1));
  assign w_dwell_done = (r_cnt == CW'(DWELL - 1));

`ifdef SCAN_SKIP_IDLE_EN
  assign w_skip = !w_sel_valid;
`else
  assign w_skip = 1'b0;
`endif

  assign w_advance = w_dwell_done || w_skip;

  // Output stage: a stalled word is held; capture uses the pre-update select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_en) begin
      r_out_data  <= w_sel_data;
      r_out_valid <= w_sel_valid;
    end
  end

  // Select sequencer: explicit load beats mode; an out-of-range load freezes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_sel <= '0;
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (sel_load) begin
        if (w_sel_legal) begin
          r_cur_sel <= sel_in;
          r_cnt     <= '0;
        end
      end else if (!mode) begin
        r_cnt <= '0;
      end else if (w_advance) begin
        r_cnt     <= '0;
        r_cur_sel <= w_last ? '0 : r_cur_sel + SW'(1);
        r_wrap    <= w_last;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign cur_sel       = r_cur_sel;
  assign wrap          = r_wrap;
endmodule

// File: tb/tb_scan_mux.sv
// Directed-vector bench for scan_mux: reset, fixed select, backpressure, scan, illegal/collision select, idle channels.
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance, DWELL=4
  scan_mux_if #(.N_CH(4), .W(8)) bus4 ();
  logic       mode4 = 1'b0;
  logic [1:0] sel_in4 = '0;
  logic       sel_load4 = 1'b0;
  logic [1:0] cur_sel4;
  logic       wrap4;

  scan_mux #(.N_CH(4), .W(8), .DWELL(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus4.master),
    .mode     (mode4),
    .sel_in   (sel_in4),
    .sel_load (sel_load4),
    .cur_sel  (cur_sel4),
    .wrap     (wrap4)
  );

  // 3-channel instance for out-of-range select and load/advance collision
  scan_mux_if #(.N_CH(3), .W(8)) bus3 ();
  logic       mode3 = 1'b0;
  logic [1:0] sel_in3 = '0;
  logic       sel_load3 = 1'b0;
  logic [1:0] cur_sel3;
  logic       wrap3;

  scan_mux #(.N_CH(3), .W(8), .DWELL(4)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus3.master),
    .mode     (mode3),
    .sel_in   (sel_in3),
    .sel_load (sel_load3),
    .cur_sel  (cur_sel3),
    .wrap     (wrap3)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int         exp_sel  [0:10];
  logic       exp_wrap [0:10];
  logic [3:0] cvp;

  initial begin
    bus4.ch_data   = '0;
    bus4.ch_valid  = '0;
    bus4.out_ready = 1'b1;
    bus3.ch_data   = {8'd3, 8'd2, 8'd1};
    bus3.ch_valid  = 3'b111;
    bus3.out_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_cur_sel", 32'(cur_sel4), 0);
    chk("rst_out_valid", 32'(bus4.out_valid), 0);
    chk("rst_out_data", 32'(bus4.out_data), 0);
    chk("rst_wrap", 32'(wrap4), 0);

    // Fixed select of channel 2
    bus4.ch_data  = {8'd44, 8'd33, 8'd22, 8'd11};
    bus4.ch_valid = 4'hF;
    sel_in4   = 2'd2;
    sel_load4 = 1'b1;
    tick();
    chk("fix_cur_sel", 32'(cur_sel4), 2);
    chk("fix_first_word", 32'(bus4.out_data), 11);
    sel_load4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fix_data_%0d", i), 32'(bus4.out_data), 33);
      chk($sformatf("fix_valid_%0d", i), 32'(bus4.out_valid), 1);
      chk($sformatf("fix_sel_%0d", i), 32'(cur_sel4), 2);
    end

    // Backpressure: held word must not follow channel changes
    bus4.out_ready = 1'b0;
    tick();
    chk("bp_hold0", 32'(bus4.out_data), 33);
    bus4.ch_data = {8'd44, 8'd55, 8'd22, 8'd11};
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), 32'(bus4.out_data), 33);
      chk($sformatf("bp_valid%0d", i), 32'(bus4.out_valid), 1);
    end
    bus4.out_ready = 1'b1;
    tick();
    chk("bp_release", 32'(bus4.out_data), 55);

    // Asynchronous reset mid-cycle with a pending word
    bus4.out_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus4.out_valid), 0);
    chk("arst_out_data", 32'(bus4.out_data), 0);
    chk("arst_cur_sel", 32'(cur_sel4), 0);
    chk("arst_wrap", 32'(wrap4), 0);
    tick();
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;

    // Auto-scan, all channels valid: 4 cycles per channel, wrap on 3->0
    bus4.ch_data  = {8'd44, 8'd33, 8'd22, 8'd11};
    bus4.ch_valid = 4'hF;
    do_reset();
    mode4 = 1'b1;
    chk("scan_sel_k0", 32'(cur_sel4), 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("scan_sel_k%0d", k), 32'(cur_sel4), 32'((k / 4) % 4));
      chk($sformatf("scan_wrap_k%0d", k), 32'(wrap4), (k == 16) ? 32'd1 : 32'd0);
    end

    // mode 1->0 mid-dwell freezes the select; 0->1 restarts a full dwell
    tick();  // k=21, cnt=1 on channel 1
    mode4 = 1'b0;
    tick();
    tick();
    tick();
    chk("freeze_sel", 32'(cur_sel4), 1);
    mode4 = 1'b1;
    tick();
    tick();
    tick();
    chk("redwell_sel_hold", 32'(cur_sel4), 1);
    tick();
    chk("redwell_sel_adv", 32'(cur_sel4), 2);
    mode4 = 1'b0;

    // 3-channel: out-of-range load ignored, load wins over advance
    mode3 = 1'b0;
    sel_in3   = 2'd2;
    sel_load3 = 1'b1;
    tick();
    chk("n3_load2", 32'(cur_sel3), 2);
    sel_in3 = 2'd3;
    tick();
    chk("n3_illegal", 32'(cur_sel3), 2);
    sel_load3 = 1'b0;
    mode3 = 1'b1;
    tick();
    tick();
    tick();
    chk("n3_pre_adv", 32'(cur_sel3), 2);
    sel_in3   = 2'd1;
    sel_load3 = 1'b1;
    tick();
    chk("n3_collide_sel", 32'(cur_sel3), 1);
    chk("n3_collide_wrap", 32'(wrap3), 0);
    sel_load3 = 1'b0;
    tick();
    tick();
    tick();
    chk("n3_cnt_clr_hold", 32'(cur_sel3), 1);
    tick();
    chk("n3_cnt_clr_adv", 32'(cur_sel3), 2);
    tick();
    tick();
    tick();
    tick();
    chk("n3_wrap_sel", 32'(cur_sel3), 0);
    chk("n3_wrap_pulse", 32'(wrap3), 1);
    tick();
    chk("n3_wrap_end", 32'(wrap3), 0);
    mode3 = 1'b0;

    // Idle channels 1 and 2 in scan mode
`ifdef SCAN_SKIP_IDLE_EN
    exp_sel  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 0};
    exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
    exp_sel  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
    exp_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    cvp = 4'b1001;
    bus4.ch_valid = cvp;
    do_reset();
    mode4 = 1'b1;
    chk("idle_sel_k0", 32'(cur_sel4), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("idle_sel_k%0d", k), 32'(cur_sel4), 32'(exp_sel[k]));
      chk($sformatf("idle_wrap_k%0d", k), 32'(wrap4), 32'(exp_wrap[k]));
      chk($sformatf("idle_valid_k%0d", k), 32'(bus4.out_valid), 32'(cvp[exp_sel[k-1]]));
    end
    mode4 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
